fwd_scoreboard: RTL and testbench
=================================

// Module: fwd_scoreboard
// PURPOSE
//  Parametrised forwarding/hazard scoreboard for the pipelined MIPS core.
//  Tracks destination registers of in-flight instructions in NSTAGE slots (slot 1 = youngest, e.g. EX).
//  Per source operand of the issuing (decode) instruction, selects the youngest forwardable producer.
//  Raises a load-use stall when that producer's data is not yet available.
// PARAMETERS
//  NSTAGE    3  tracked post-issue stages (slot 1..NSTAGE)
//  NSRC      2  source operands per issuing instruction
//  REGW      5  register index width
//  LOAD_LAT  1  load result forwardable only from slot k > LOAD_LAT
//  SELW      $clog2(NSTAGE+1)  derived local width of one select field
// PORTS
//  CLK           in   1          core clock, all state on rising edge
//  RST           in   1          synchronous reset, active-high
//  issue_valid   in   1          decode stage holds a real instruction
//  issue_rd      in   REGW       its destination register
//  issue_wr      in   1          it writes the register file
//  issue_load    in   1          it is a load (data late)
//  src_reg       in   NSRC*REGW  source register indices, operand i at [i*REGW +: REGW]
//  src_used      in   NSRC       operand i is actually read
//  stall_ext     in   1          downstream freeze (memory wait); hold all slots
//  flush         in   1          branch/jump squash of the issuing instruction and slot 1
//  fwd_sel       out  NSRC*SELW  per operand: 0 = register file, k = forward from slot k
//  hazard_stall  out  1          hold fetch/decode, inject bubble into slot 1
// BEHAVIOUR
//  Slot state: {valid, rd, wr, load}. Reset: all valid=0. fwd_sel=0 and hazard_stall=0 out of reset.
//  Match(i,k): valid_k & wr_k & rd_k==src_i & src_i!=0 & src_used[i]. $0 is never forwarded.
//  fwd_sel[i] = smallest k with Match(i,k), else 0. Combinational; same-cycle valid.
//  ready_k = !load_k | (k > LOAD_LAT).
//  hazard_stall = issue_valid & !flush & OR_i(sel_i!=0 & !ready_sel_i). Combinational.
//  Slot update, evaluated in priority order each cycle:
//   1. RST: all slots invalid.
//   2. stall_ext: slots 2..NSTAGE hold. Slot 1 holds, or is cleared if flush.
//   3. flush: slot 1 <= bubble; slots shift (k+1 <= k); the issuing instruction is discarded.
//   4. hazard_stall: slot 1 <= bubble; slots shift.
//   5. Otherwise: slot 1 <= {issue_valid, issue_rd, issue_wr, issue_load}; slots shift.
//  The entry in slot NSTAGE drops off on shift. Latency: an accepted issue is visible in slot 1 next cycle.
//  Bubble = valid 0; a bubble never matches.
//  Stall resolution: a stalled load-use re-evaluates each cycle. It clears automatically once the load passes slot LOAD_LAT.
//  Duplicate rd in two slots: the youngest (lowest k) wins; the older one is ignored.
//  RST asserted mid-stall: the next cycle has empty slots, so hazard_stall deasserts.
//  No combinational path from fwd_sel/hazard_stall back into slot state other than rule 4.
// CONFIGURATION
//  FWD_SCOREBOARD_STATS_EN defined: adds outputs
//   stall_cnt  out 32  cycles with hazard_stall=1 and stall_ext=0
//   fwd_cnt    out 32  cycles with issue accepted (rule 5) and any fwd_sel!=0
//   Both saturate at 32'hFFFF_FFFF and reset to 0 on RST.
//  Not defined: ports and counters absent; core function unchanged.
// TESTING
//  1. Reset: RST=1 for 2 cycles with random inputs -> fwd_sel=0, hazard_stall=0 on the cycle after release.
//  2. ALU chain: add $3 issued, next issue reads rs=$3 -> fwd_sel[0]=1. One instr later -> 2. Two later -> 3. Then 0.
//  3. Load-use: lw $5 (LOAD_LAT=1), next reads $5 -> hazard_stall=1 for exactly 1 cycle, slot 1 bubble,
//     then fwd_sel=2 and no stall.
//  4. $0 and unused operands: writer rd=$0, reader src=$0 -> fwd_sel=0. src_used=0 on a matching reg -> 0, no stall.
//  5. Youngest wins: slot 1 and slot 3 both rd=$7, reader $7 -> fwd_sel=1.
//  6. Events: stall_ext=1 for 3 cycles -> slots frozen, outputs stable. flush with load-use pending -> hazard_stall=0,
//     slot 1 bubble next cycle. FWD_SCOREBOARD_STATS_EN build of test 3 -> stall_cnt=1.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: tracks in-flight destination registers and selects forward sources.
// Optional statistics counters are enabled by defining FWD_SCOREBOARD_STATS_EN.
module fwd_scoreboard #(
  parameter int unsigned NSTAGE   = 3,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned REGW     = 5,
  parameter int unsigned LOAD_LAT = 1,
  localparam int unsigned SELW    = $clog2(NSTAGE + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 issue_valid,
  input  logic [REGW-1:0]      issue_rd,
  input  logic                 issue_wr,
  input  logic                 issue_load,
  input  logic [NSRC*REGW-1:0] src_reg,
  input  logic [NSRC-1:0]      src_used,
  input  logic                 stall_ext,
  input  logic                 flush,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic                 hazard_stall
`ifdef FWD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          fwd_cnt
`endif
);

  // Slot k holds the instruction k stages past decode; slot 1 is the youngest.
  logic [NSTAGE:1] valid_q;
  logic [NSTAGE:1] wr_q;
  logic [NSTAGE:1] load_q;
  logic [REGW-1:0] rd_q [NSTAGE:1];

  logic [NSTAGE:0] ready;
  logic [REGW-1:0] src  [NSRC];
  logic [SELW-1:0] sel  [NSRC];
  logic [NSRC-1:0] op_wait;

  // Index 0 stands for the register file, which is always ready.
  always_comb begin
    ready[0] = 1'b1;
    for (int k = 1; k <= int'(NSTAGE); k++) begin
      ready[k] = !load_q[k] || (k > int'(LOAD_LAT));
    end
  end

  // Scan oldest to youngest so the youngest matching slot overwrites the selection.
  always_comb begin
    fwd_sel = '0;
    op_wait = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      src[i] = src_reg[i*REGW +: REGW];
      sel[i] = '0;
      for (int k = int'(NSTAGE); k >= 1; k--) begin
        if (valid_q[k] && wr_q[k] && (rd_q[k] == src[i]) && (src[i] != '0) && src_used[i]) begin
          sel[i] = SELW'(k);
        end
      end
      op_wait[i]                 = (sel[i] != '0) && !ready[sel[i]];
      fwd_sel[i*SELW +: SELW]    = sel[i];
    end
  end

  assign hazard_stall = issue_valid && !flush && (|op_wait);

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
    end else if (stall_ext) begin
      if (flush) begin
        valid_q[1] <= 1'b0;
      end
    end else begin
      for (int k = int'(NSTAGE); k >= 2; k--) begin
        valid_q[k] <= valid_q[k-1];
      end
      valid_q[1] <= issue_valid && !flush && !hazard_stall;
    end
  end

  // Payload needs no reset: it is only observed through a valid slot.
  always_ff @(posedge CLK) begin
    if (!RST && !stall_ext) begin
      for (int k = int'(NSTAGE); k >= 2; k--) begin
        rd_q[k]   <= rd_q[k-1];
        wr_q[k]   <= wr_q[k-1];
        load_q[k] <= load_q[k-1];
      end
      rd_q[1]   <= issue_rd;
      wr_q[1]   <= issue_wr;
      load_q[1] <= issue_load;
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  logic accept;
  assign accept = issue_valid && !stall_ext && !flush && !hazard_stall;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (hazard_stall && !stall_ext && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (accept && (|fwd_sel) && (fwd_cnt != '1)) begin
        fwd_cnt <= fwd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Table-driven bench for fwd_scoreboard with a queue of expected outputs per driven cycle.
module tb_fwd_scoreboard;

  logic       CLK = 1'b0;
  logic       RST;
  logic       issue_valid;
  logic [4:0] issue_rd;
  logic       issue_wr;
  logic       issue_load;
  logic [9:0] src_reg;
  logic [1:0] src_used;
  logic       stall_ext;
  logic       flush;
  logic [3:0] fwd_sel;
  logic       hazard_stall;
`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
`endif

  fwd_scoreboard dut (
    .CLK          (CLK),
    .RST          (RST),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_wr     (issue_wr),
    .issue_load   (issue_load),
    .src_reg      (src_reg),
    .src_used     (src_used),
    .stall_ext    (stall_ext),
    .flush        (flush),
    .fwd_sel      (fwd_sel),
    .hazard_stall (hazard_stall)
`ifdef FWD_SCOREBOARD_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .fwd_cnt      (fwd_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, stx, fl, iv;
    logic [4:0] rd;
    logic       wr, ld;
    logic [4:0] s0, s1;
    logic [1:0] used;
    logic [1:0] e0, e1;
    logic       es;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] sel;
    logic       st;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(logic rst, logic stx, logic fl, logic iv, logic [4:0] rd,
                              logic wr, logic ld, logic [4:0] s0, logic [4:0] s1,
                              logic [1:0] used, logic [1:0] e0, logic [1:0] e1, logic es);
    vec_t v;
    v.rst = rst; v.stx = stx; v.fl = fl; v.iv = iv; v.rd = rd; v.wr = wr; v.ld = ld;
    v.s0 = s0; v.s1 = s1; v.used = used; v.e0 = e0; v.e1 = e1; v.es = es;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic drive(vec_t v);
    RST = v.rst; stall_ext = v.stx; flush = v.fl; issue_valid = v.iv; issue_rd = v.rd;
    issue_wr = v.wr; issue_load = v.ld; src_reg = {v.s1, v.s0}; src_used = v.used;
  endtask

  task automatic check_front(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " queue empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("%s%0d fwd_sel", tag, e.idx), {28'd0, fwd_sel}, {28'd0, e.sel});
      chk($sformatf("%s%0d hazard_stall", tag, e.idx), {31'd0, hazard_stall}, {31'd0, e.st});
    end
  endtask

  initial begin
    //        rst stx fl iv rd  wr ld s0  s1  used  e0 e1 es
    tbl.push_back(mk(0, 0, 0, 1,  3, 1, 0,  0,  0, 2'b00, 0, 0, 0)); // r0  add $3
    tbl.push_back(mk(0, 0, 0, 1, 10, 1, 0,  3,  0, 2'b01, 1, 0, 0)); // r1
    tbl.push_back(mk(0, 0, 0, 1, 11, 1, 0,  3,  0, 2'b01, 2, 0, 0)); // r2
    tbl.push_back(mk(0, 0, 0, 1, 12, 1, 0,  3, 10, 2'b11, 3, 2, 0)); // r3
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,  3, 12, 2'b11, 0, 1, 0)); // r4  $3 gone
    tbl.push_back(mk(0, 0, 0, 1,  5, 1, 1,  0,  0, 2'b00, 0, 0, 0)); // r5  lw $5
    tbl.push_back(mk(0, 0, 0, 1,  6, 1, 0,  5,  0, 2'b01, 1, 0, 1)); // r6  load-use
    tbl.push_back(mk(0, 0, 0, 1,  6, 1, 0,  5,  0, 2'b01, 2, 0, 0)); // r7  resolved
    tbl.push_back(mk(0, 0, 0, 1,  0, 1, 0,  6,  0, 2'b01, 1, 0, 0)); // r8  writer $0
    tbl.push_back(mk(0, 0, 0, 1,  7, 1, 0,  0,  6, 2'b01, 0, 0, 0)); // r9  $0 / unused
    tbl.push_back(mk(0, 0, 0, 1,  9, 1, 1,  0,  0, 2'b00, 0, 0, 0)); // r10 lw $9
    tbl.push_back(mk(0, 0, 0, 1,  7, 1, 0,  9,  7, 2'b10, 0, 2, 0)); // r11 unused load src
    tbl.push_back(mk(0, 0, 0, 1, 13, 0, 0,  7,  9, 2'b11, 1, 2, 0)); // r12 youngest wins
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 13,  9, 2'b11, 0, 3, 0)); // r13 non-writer
    tbl.push_back(mk(0, 0, 0, 1, 20, 1, 1,  7,  0, 2'b01, 3, 0, 0)); // r14 lw $20
    tbl.push_back(mk(0, 1, 0, 1, 21, 1, 0, 20, 13, 2'b11, 1, 0, 1)); // r15 frozen
    tbl.push_back(mk(0, 1, 0, 1, 21, 1, 0, 20, 13, 2'b11, 1, 0, 1)); // r16 frozen
    tbl.push_back(mk(0, 1, 0, 1, 21, 1, 0, 20, 13, 2'b11, 1, 0, 1)); // r17 frozen
    tbl.push_back(mk(0, 0, 0, 1, 21, 1, 0, 20, 13, 2'b11, 1, 0, 1)); // r18
    tbl.push_back(mk(0, 0, 0, 1, 21, 1, 0, 20,  0, 2'b01, 2, 0, 0)); // r19
    tbl.push_back(mk(0, 0, 0, 1, 22, 1, 1, 21,  0, 2'b01, 1, 0, 0)); // r20 lw $22
    tbl.push_back(mk(0, 0, 1, 1, 23, 1, 0, 22, 21, 2'b11, 1, 2, 0)); // r21 flush
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 23, 22, 2'b11, 0, 2, 0)); // r22 $23 discarded
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 21, 22, 2'b11, 0, 3, 0)); // r23 $21 dropped
    tbl.push_back(mk(0, 0, 0, 1, 24, 1, 1,  0,  0, 2'b00, 0, 0, 0)); // r24 lw $24
    tbl.push_back(mk(0, 1, 1, 1, 25, 1, 0, 24,  0, 2'b01, 1, 0, 0)); // r25 stall_ext+flush
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 24,  0, 2'b01, 0, 0, 0)); // r26 slot 1 cleared
    tbl.push_back(mk(0, 0, 0, 1, 26, 1, 1,  0,  0, 2'b00, 0, 0, 0)); // r27 lw $26
    tbl.push_back(mk(1, 0, 0, 1, 27, 1, 0, 26,  0, 2'b01, 1, 0, 1)); // r28 RST mid-stall
    tbl.push_back(mk(0, 0, 0, 1, 27, 1, 0, 26,  0, 2'b01, 0, 0, 0)); // r29 slots empty

    // Two reset cycles with random inputs.
    RST = 1'b1; stall_ext = 1'($urandom); flush = 1'($urandom); issue_valid = 1'($urandom);
    issue_rd = 5'($urandom); issue_wr = 1'($urandom); issue_load = 1'($urandom);
    src_reg = 10'($urandom); src_used = 2'($urandom);
    @(posedge CLK); #1;
    stall_ext = 1'($urandom); flush = 1'($urandom); issue_valid = 1'($urandom);
    issue_rd = 5'($urandom); issue_wr = 1'($urandom); issue_load = 1'($urandom);
    src_reg = 10'($urandom); src_used = 2'($urandom);
    @(posedge CLK); #1;
    RST = 1'b0; stall_ext = 1'b0; flush = 1'b0; issue_valid = 1'b0;
    src_reg = {5'($urandom_range(31, 1)), 5'($urandom_range(31, 1))}; src_used = 2'b11;
    sb.push_back('{idx: 0, sel: 4'd0, st: 1'b0});
    @(negedge CLK);
    check_front("reset");

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge CLK); #1;
      drive(tbl[i]);
      sb.push_back('{idx: i, sel: {tbl[i].e1, tbl[i].e0}, st: tbl[i].es});
      @(negedge CLK);
      check_front("row");
`ifdef FWD_SCOREBOARD_STATS_EN
      if (i == 7) chk("stall_cnt after load-use", stall_cnt, 32'd1);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
